multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the RV32I core. Sequences fetch, decode, execute, memory and writeback around the instruction decoder, ALU, register file and a single shared instruction/data memory port.
- Consumes the opcode and funct3 fields plus the branch-compare result.
- Produces per-state datapath strobes, a request/ready memory handshake and a retired-instruction counter.

---
 rtl/multicycle_ctrl.sv | 169 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing with a shared memory port.
// ILLEGAL_TRAP_EN: illegal opcodes enter a sticky TRAP state instead of being skipped as NOPs.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [2:0]       mem_size,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             alu_a_pc,
  output logic             alu_b_imm,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             trap
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_auipc, is_lui, is_legal;

  always_comb begin
    is_r      = (opcode == 7'b0110011);
    is_i      = (opcode == 7'b0010011);
    is_load   = (opcode == 7'b0000011);
    is_store  = (opcode == 7'b0100011);
    is_branch = (opcode == 7'b1100011);
    is_jal    = (opcode == 7'b1101111);
    is_jalr   = (opcode == 7'b1100111);
    is_auipc  = (opcode == 7'b0010111);
    is_lui    = (opcode == 7'b0110111);
    is_legal  = is_r | is_i | is_load | is_store | is_branch |
                is_jal | is_jalr | is_auipc | is_lui;
  end

  always_comb begin
    state_d   = state_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_size  = '0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    reg_we    = 1'b0;
    wb_sel    = 2'd0;
    alu_a_pc  = 1'b0;
    alu_b_imm = 1'b0;
    trap      = 1'b0;
    retire    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          pc_we   = 1'b1;
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        alu_b_imm = is_i | is_load | is_store | is_jalr | is_auipc;
        alu_a_pc  = is_auipc;
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          pc_we   = 1'b1;
          pc_sel  = br_taken ? 2'd1 : 2'd0;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = is_store;
        mem_size = funct3;
        if (mem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        wb_sel  = is_load ? 2'd1 : (is_jal || is_jalr) ? 2'd2 : is_lui ? 2'd3 : 2'd0;
        pc_we   = 1'b1;
        pc_sel  = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
        trap = 1'b1;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase

    // Reset blanks every strobe, including an in-flight request or store retire.
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_size  = '0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 2'd0;
      reg_we    = 1'b0;
      wb_sel    = 2'd0;
      alu_a_pc  = 1'b0;
      alu_b_imm = 1'b0;
      trap      = 1'b0;
      retire    = 1'b0;
    end

    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl; narrow retired counter exercises wrap-around.
module tb_multicycle_ctrl;

  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          br_taken;
  logic          mem_ready;
  logic          mem_req, mem_we, ir_we, pc_we, reg_we, alu_a_pc, alu_b_imm, trap;
  logic [2:0]    mem_size, state;
  logic [1:0]    pc_sel, wb_sel;
  logic [CW-1:0] retired;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .br_taken(br_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
    .alu_a_pc(alu_a_pc), .alu_b_imm(alu_b_imm), .state(state), .retired(retired),
    .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    st;
    logic          req;
    logic          we;
    logic [2:0]    sz;
    logic          irwe;
    logic          pcwe;
    logic [1:0]    pcsel;
    logic          regwe;
    logic [1:0]    wbsel;
    logic          apc;
    logic          bimm;
    logic          trp;
    logic [CW-1:0] ret;
  } obs_t;

  typedef struct {
    logic  rs;
    logic  rdy;
    obs_t  exp;
    string tag;
  } row_t;

  row_t          sb[$];
  logic [CW-1:0] exp_ret;
  int            checks   = 0;
  int            failures = 0;

  function automatic obs_t mk(input logic [2:0] st, input logic req, input logic we,
                              input logic [2:0] sz, input logic irwe, input logic pcwe,
                              input logic [1:0] pcsel, input logic regwe,
                              input logic [1:0] wbsel, input logic apc, input logic bimm,
                              input logic trp);
    obs_t o;
    o.st = st; o.req = req; o.we = we; o.sz = sz; o.irwe = irwe; o.pcwe = pcwe;
    o.pcsel = pcsel; o.regwe = regwe; o.wbsel = wbsel; o.apc = apc; o.bimm = bimm;
    o.trp = trp; o.ret = exp_ret;
    return o;
  endfunction

  task automatic push(input logic rs, input logic rdy, input obs_t e, input string t);
    row_t r;
    r.rs = rs; r.rdy = rdy; r.exp = e; r.tag = t;
    sb.push_back(r);
  endtask

  task automatic drain();
    row_t r;
    obs_t o;
    while (sb.size() > 0) begin
      r = sb.pop_front();
      rst = r.rs;
      mem_ready = r.rdy;
      @(negedge clk);
      o.st = state; o.req = mem_req; o.we = mem_we; o.sz = mem_size; o.irwe = ir_we;
      o.pcwe = pc_we; o.pcsel = pc_sel; o.regwe = reg_we; o.wbsel = wb_sel;
      o.apc = alu_a_pc; o.bimm = alu_b_imm; o.trp = trap; o.ret = retired;
      checks++;
      assert (o === r.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", r.tag, o, r.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_seq(input logic [2:0] cur_st, input string nm);
    // First reset cycle still shows the old state but every strobe is blanked.
    push(1'b1, 1'b1, mk(cur_st, 0, 0, 3'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0), {nm, "_rst0"});
    exp_ret = '0;
    push(1'b1, 1'b0, mk(3'd0, 0, 0, 3'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0), {nm, "_rst1"});
    drain();
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic b,
                       input int unsigned fw, input int unsigned mw, input logic abort,
                       input string nm);
    logic ld, stw, br, jal, jalr, auipc, lui, ii, rr, legal, bimm;
    logic [1:0] ws, ps;
    ld = (op == 7'b0000011); stw = (op == 7'b0100011); br = (op == 7'b1100011);
    jal = (op == 7'b1101111); jalr = (op == 7'b1100111); auipc = (op == 7'b0010111);
    lui = (op == 7'b0110111); ii = (op == 7'b0010011); rr = (op == 7'b0110011);
    legal = ld | stw | br | jal | jalr | auipc | lui | ii | rr;
    opcode = op; funct3 = f3; br_taken = b;

    for (int i = 0; i < int'(fw); i++)
      push(0, 0, mk(3'd0, 1, 0, 3'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0), {nm, "_fetchwait"});
    push(0, 1, mk(3'd0, 1, 0, 3'd0, 1, 0, 2'd0, 0, 2'd0, 0, 0, 0), {nm, "_fetch"});

    if (!legal) begin
`ifdef ILLEGAL_TRAP_EN
      push(0, 1, mk(3'd1, 0, 0, 3'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0), {nm, "_decode"});
      for (int i = 0; i < 20; i++)
        push(0, 1, mk(3'd5, 0, 0, 3'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 1), {nm, "_trap"});
`else
      push(0, 1, mk(3'd1, 0, 0, 3'd0, 0, 1, 2'd0, 0, 2'd0, 0, 0, 0), {nm, "_skip"});
`endif
      drain();
      return;
    end

    push(0, 1, mk(3'd1, 0, 0, 3'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0), {nm, "_decode"});

    bimm = ii | ld | stw | jalr | auipc;
    if (br) begin
      push(0, 1, mk(3'd2, 0, 0, 3'd0, 0, 1, {1'b0, b}, 0, 2'd0, 0, 0, 0), {nm, "_exec"});
      exp_ret++;
    end else begin
      push(0, 1, mk(3'd2, 0, 0, 3'd0, 0, 0, 2'd0, 0, 2'd0, auipc, bimm, 0), {nm, "_exec"});
    end

    if (ld || stw) begin
      for (int i = 0; i < int'(mw); i++)
        push(0, 0, mk(3'd3, 1, stw, f3, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0), {nm, "_memwait"});
      if (abort) begin
        drain();
        return;
      end
      push(0, 1, mk(3'd3, 1, stw, f3, 0, stw, 2'd0, 0, 2'd0, 0, 0, 0), {nm, "_mem"});
      if (stw) exp_ret++;
    end

    if (!(br || stw)) begin
      ws = ld ? 2'd1 : (jal || jalr) ? 2'd2 : lui ? 2'd3 : 2'd0;
      ps = jal ? 2'd1 : jalr ? 2'd2 : 2'd0;
      push(0, 1, mk(3'd4, 0, 0, 3'd0, 0, 1, ps, 1, ws, 0, 0, 0), {nm, "_wb"});
      exp_ret++;
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b0; opcode = '0; funct3 = '0; br_taken = 1'b0;
    exp_ret = '0;
    repeat (2) @(posedge clk);
    #1;
    push(1, 0, mk(3'd0, 0, 0, 3'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0), "reset");
    drain();

    instr(7'b0110011, 3'b000, 0, 0, 0, 0, "add");
    instr(7'b0000011, 3'b010, 0, 3, 2, 0, "lw");
    instr(7'b1100011, 3'b000, 1, 0, 0, 0, "beq_t");
    instr(7'b1100011, 3'b000, 0, 0, 0, 0, "beq_nt");
    instr(7'b1100111, 3'b000, 0, 0, 0, 0, "jalr");
    instr(7'b0110111, 3'b000, 0, 0, 0, 0, "lui");
    instr(7'b0100011, 3'b010, 0, 0, 0, 0, "sw");
    instr(7'b1101111, 3'b000, 0, 0, 0, 0, "jal_wrap");
    instr(7'b0010111, 3'b000, 0, 0, 0, 0, "auipc");
    instr(7'b0010011, 3'b000, 0, 1, 0, 0, "addi");
    instr(7'b1111111, 3'b000, 0, 0, 0, 0, "illegal");
`ifdef ILLEGAL_TRAP_EN
    reset_seq(3'd5, "trap");
`endif
    instr(7'b0110011, 3'b000, 0, 0, 0, 0, "add2");
    instr(7'b0100011, 3'b001, 0, 1, 2, 1, "sw_abort");
    reset_seq(3'd3, "sw_abort");
    instr(7'b0110011, 3'b000, 0, 0, 0, 0, "add3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
